// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit serializer. Accepts one parallel word over a valid/ready
//   handshake and shifts it out LSB-first as: start bit, DATA_BITS data bits,
//   optional parity bit, STOP_BITS stop bits. Every bit boundary is aligned
//   to the one-cycle clock_enable pulse from the baud divider; everything
//   runs on system_clock.
//
// Ports
//   system_clock  in   system clock, rising edge
//   rst_n         in   asynchronous reset, active low
//   clock_enable  in   baud tick, one-cycle pulse per bit period
//   tx_data       in   word to send, sampled on handshake only
//   tx_valid      in   upstream has a word on tx_data
//   tx_ready      out  word can be accepted (IDLE only)
//   tx            out  serial line, registered, idle level 1
//   tx_busy       out  state is not IDLE
//   tx_done       out  one-cycle pulse as the last stop bit period ends
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 system_clock,
  input  logic                 rst_n,
  input  logic                 clock_enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);
  localparam bit                HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q,   par_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 stop_q,  stop_d;
  logic                 tx_q,    tx_d;

  logic                 last_data;
  logic                 last_stop;

  assign last_data = (idx_q == LAST_IDX);
  assign last_stop = (stop_q == LAST_STOP);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state. IDLE->ARMED is the only move not gated by the tick, so a
  // tick that coincides with the handshake is seen in IDLE and dropped; the
  // start bit therefore always gets a full tick period.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx_valid) state_d = S_ARMED;
      S_ARMED:  if (clock_enable) state_d = S_START;
      S_START:  if (clock_enable) state_d = S_DATA;
      S_DATA:   if (clock_enable && last_data)
                  state_d = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (clock_enable) state_d = S_STOP;
      S_STOP:   if (clock_enable && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    tx_busy  = (state_q != S_IDLE);
    tx_done  = (state_q == S_STOP) && clock_enable && last_stop;
  end

  assign tx = tx_q;

  // -------------------------------------------------------------------------
  // Datapath next state. The shift register is consumed from bit 0: the START
  // tick puts d0 on the line, each DATA tick puts the next bit on the line,
  // so bit_idx counts data bits already driven beyond d0.
  // -------------------------------------------------------------------------
  always_comb begin
    shreg_d = shreg_q;
    par_d   = par_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shreg_d = tx_data;
          par_d   = (^tx_data) ^ PAR_INV;
        end
      end
      S_ARMED: begin
        if (clock_enable) tx_d = 1'b0;
      end
      S_START: begin
        if (clock_enable) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (clock_enable) begin
          if (!last_data) begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end else if (HAS_PAR) begin
            tx_d = par_q;
          end else begin
            tx_d   = 1'b1;
            stop_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (clock_enable) begin
          tx_d   = 1'b1;
          stop_d = 1'b0;
        end
      end
      S_STOP: begin
        if (clock_enable && !last_stop) stop_d = stop_q + 1'b1;
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. tx resets straight to mark level so an abort mid-frame
  // never drives a spurious low onto the line.
  // -------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four serializer configurations (8N1, 8E1, 8O1, 8N2) run side by side on a
//   shared clock, tick and reset. Each has its own driver and a frame-level
//   reference model: on acceptance the expected line image (start, data LSB
//   first, parity, stops) is built as a bit vector, and the model just counts
//   ticks into it. tx, tx_busy, tx_ready and tx_done are compared every cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int NCFG = 4;
  localparam int NDIR = 6;
  localparam logic [7:0] DIR [NDIR] = '{8'hFF, 8'hA5, 8'h07, 8'h00, 8'h55, 8'hAA};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic run_rand = 1'b0;
  int   ce_per = 4;
  int   ce_cnt = 0;

  int n_chk  = 0;
  int n_pass = 0;

  logic       tx_a   [NCFG];
  logic       busy_a [NCFG];
  logic       rdy_a  [NCFG];
  logic       done_a [NCFG];
  logic       act_a  [NCFG];
  logic [3:0] idx_a  [NCFG];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Expected line image, bit i is the i-th bit period after the idle wait.
  // Positions past the parity bit default to 1 and serve as stop bits.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input int pe, input int po);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pe != 0) f[9] = (^d) ^ (po != 0);
    return f;
  endfunction

  // Shared tick generator: ce_per==0 holds the tick high continuously.
  always @(posedge clk) begin
    #1;
    if (ce_per == 0) ce = 1'b1;
    else begin
      ce = (ce_cnt == 0);
      ce_cnt = (ce_cnt + 1 >= ce_per) ? 0 : ce_cnt + 1;
    end
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    localparam int NB = 1 + 8 + PE + SB;

    logic [7:0]  data  = 8'h00;
    logic        valid = 1'b0;
    logic        ready, txw, busy, done;
    logic        m_act;
    int          m_k;
    logic [11:0] m_frame;
    logic [3:0]  idx = 4'd0;

    uart_tx_serializer #(
      .DATA_BITS (8),
      .PARITY_EN (PE),
      .PARITY_ODD(PO),
      .STOP_BITS (SB)
    ) u_dut (
      .system_clock(clk),
      .rst_n       (rst_n),
      .clock_enable(ce),
      .tx_data     (data),
      .tx_valid    (valid),
      .tx_ready    (ready),
      .tx          (txw),
      .tx_busy     (busy),
      .tx_done     (done)
    );

    assign tx_a[g]   = txw;
    assign busy_a[g] = busy;
    assign rdy_a[g]  = ready;
    assign done_a[g] = done;
    assign act_a[g]  = m_act;
    assign idx_a[g]  = idx;

    // Reference model: m_k = ticks consumed since acceptance.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_act <= 1'b0;
        m_k   <= 0;
      end else if (m_act) begin
        if (ce) begin
          if (m_k == NB) m_act <= 1'b0;
          m_k <= m_k + 1;
        end
      end else if (valid) begin
        m_act   <= 1'b1;
        m_k     <= 0;
        m_frame <= mk_frame(data, PE, PO);
        if (!run_rand && idx < NDIR) idx <= idx + 4'd1;
      end
    end

    // Driver: directed list with valid held, then random valid/data. Data
    // keeps changing mid-frame in the random phase.
    always @(posedge clk) begin
      #1;
      if (!run_rand) begin
        valid = (idx < NDIR);
        data  = DIR[(idx < NDIR) ? int'(idx) : 0];
      end else begin
        valid = ($urandom_range(0, 3) != 0);
        data  = 8'($urandom);
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("c%0d_tx", g),    txw,   (m_act && m_k >= 1) ? m_frame[m_k-1] : 1'b1);
        chk($sformatf("c%0d_busy", g),  busy,  m_act);
        chk($sformatf("c%0d_ready", g), ready, !m_act);
        chk($sformatf("c%0d_done", g),  done,  m_act && ce && (m_k == NB));
      end
    end
  end

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NCFG; i++) if (idx_a[i] != NDIR || act_a[i]) r = 1'b0;
    return r;
  endfunction

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("%s_tx%0d", tag, i),    tx_a[i],   1'b1);
      chk($sformatf("%s_busy%0d", tag, i),  busy_a[i], 1'b0);
      chk($sformatf("%s_ready%0d", tag, i), rdy_a[i],  1'b1);
      chk($sformatf("%s_done%0d", tag, i),  done_a[i], 1'b0);
    end
  endtask

  initial begin
    bit ok;
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n = 1'b1;

    // First directed word 0xFF; abort it while in the data bits.
    repeat (26) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Remaining directed words, back to back with valid held.
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 3000 && !ok) begin
      @(posedge clk);
      cyc++;
      ok = all_idle();
    end
    chk("directed_complete", ok, 1'b1);

    // Random traffic under varying tick spacing, including continuous ticks.
    run_rand = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      ce_per = $urandom_range(0, 5);
      repeat (250) @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
